// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline stage register with valid/ready handshake, optional two-entry skid buffer,
// flush (bubble) insertion and forcing of the control bundle to a no-op when the stage is empty.
module id_ex_stage_reg #(
  parameter int unsigned       CTRL_W   = 10,
  parameter int unsigned       DATA_W   = 143,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter bit                SKID     = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // Decode side
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  // Execute side
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              ready_q;
  logic              in_fire, out_fire;
  logic              main_we, skid_we, main_from_skid;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;

  assign in_fire  = valid_i && ready_o;
  assign out_fire = valid_o && ready_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and entry-load decode
  always_comb begin
    state_d        = state_q;
    main_we        = 1'b0;
    skid_we        = 1'b0;
    main_from_skid = 1'b0;
    if (flush_i) begin
      // Held beats and any beat offered this cycle are dropped; an output
      // transfer in this cycle still completes on the execute side.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StOne;
            main_we = 1'b1;
          end
        end
        StOne: begin
          unique case ({in_fire, out_fire})
            2'b10: begin
              state_d = StFull;
              skid_we = SKID;
            end
            2'b01:   state_d = StEmpty;
            2'b11:   main_we = 1'b1;
            default: state_d = StOne;
          endcase
        end
        StFull: begin
          if (out_fire) begin
            state_d        = StOne;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Registered ready reflects the occupancy the stage will have after this edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (state_d != StFull);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_ctrl_q <= CTRL_NOP;
      main_data_q <= '0;
    end else if (main_we) begin
      main_ctrl_q <= ctrl_i;
      main_data_q <= data_i;
    end else if (main_from_skid) begin
      main_ctrl_q <= skid_ctrl_q;
      main_data_q <= skid_data_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skid_ctrl_q <= CTRL_NOP;
      skid_data_q <= '0;
    end else if (skid_we) begin
      skid_ctrl_q <= ctrl_i;
      skid_data_q <= data_i;
    end
  end

  // Outputs
  always_comb begin
    valid_o = (state_q != StEmpty);
    ctrl_o  = valid_o ? main_ctrl_q : CTRL_NOP;
    data_o  = main_data_q;
    count_o = state_q;
    if (rst_i) begin
      ready_o = 1'b0;
    end else if (SKID) begin
      ready_o = ready_q;
    end else begin
      ready_o = ready_i || !valid_o;
    end
  end

  a_nop_when_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    !valid_o |-> (ctrl_o == CTRL_NOP));
  a_no_accept_full: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == StFull) |-> !ready_o);
  a_single_entry: assert property (@(posedge clk_i) disable iff (rst_i)
    !SKID |-> (state_q != StFull));

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomised scoreboard bench for id_ex_stage_reg; one SKID=1 and one SKID=0 instance share
// stimulus, each checked against its own queue-based reference model.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic [9:0]   ctrl;
    logic [142:0] data;
  } beat_t;

  logic         clk;
  logic         rst_i;
  logic         valid_i;
  logic         flush_i;
  logic         ready_i;
  logic [9:0]   ctrl_i;
  logic [142:0] data_i;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int inst, input logic [159:0] act,
                       input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got %0h, expected %0h", name, inst, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam bit Skid = (g == 0);

    logic         ready_o;
    logic         valid_o;
    logic [9:0]   ctrl_o;
    logic [142:0] data_o;
    logic [1:0]   count_o;

    beat_t exp_q[$];
    logic  model_ready = 1'b0;
    logic  rst_applied = 1'b0;

    id_ex_stage_reg #(
      .CTRL_W(10),
      .DATA_W(143),
      .SKID  (Skid)
    ) u_dut (
      .clk_i  (clk),
      .rst_i  (rst_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .ctrl_i (ctrl_i),
      .data_i (data_i),
      .flush_i(flush_i),
      .valid_o(valid_o),
      .ready_i(ready_i),
      .ctrl_o (ctrl_o),
      .data_o (data_o),
      .count_o(count_o)
    );

    // Monitor: compare presented state, pop on every output transfer.
    always @(negedge clk) begin
      beat_t head;
      int    sz;
      sz   = exp_q.size();
      head = (sz > 0) ? exp_q[0] : '0;
      model_ready = rst_i ? 1'b0 : (Skid ? (sz < 2) : (ready_i || sz == 0));
      check("ready_o", g, 160'(ready_o), 160'(model_ready));
      check("valid_o", g, 160'(valid_o), 160'(sz > 0));
      check("count_o", g, 160'(count_o), 160'(sz));
      check("ctrl_o", g, 160'(ctrl_o), 160'((sz > 0) ? head.ctrl : 10'h000));
      if (rst_applied) check("reset data_o", g, 160'(data_o), 160'(0));
      if (!rst_i && valid_o === 1'b1 && ready_i) begin
        if (sz == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected beat dut%0d at %0t: got data %0h, expected none", g, $time,
                   data_o);
        end else begin
          check("out data", g, 160'(data_o), 160'(head.data));
          check("out ctrl", g, 160'(ctrl_o), 160'(head.ctrl));
          void'(exp_q.pop_front());
        end
      end
    end

    // Reference model: what the stage holds after the coming edge.
    always @(negedge clk) begin
      #1;
      rst_applied = rst_i;
      if (rst_i || flush_i) exp_q.delete();
      else if (valid_i && model_ready) exp_q.push_back(beat_t'({ctrl_i, data_i}));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data(output logic [142:0] d);
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    d = t[142:0];
  endtask

  task automatic idle(input int n, input logic rdy);
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = rdy;
    repeat (n) step();
  endtask

  // Offer beats 1..n, holding each until the SKID=1 instance accepts it.
  task automatic stream(input int n, input int stall_at, input int stall_len);
    int i   = 1;
    int cyc = 0;
    while (i <= n && cyc < 200) begin
      valid_i = 1'b1;
      data_i  = 143'(i);
      ctrl_i  = 10'($urandom);
      ready_i = !(cyc >= stall_at && cyc < stall_at + stall_len);
      @(negedge clk);
      if (g_dut[0].ready_o) i++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (i <= n) begin
      checks++;
      errors++;
      $display("FAIL stream timeout: got %0d beats accepted, expected %0d", i - 1, n);
    end
    idle(4, 1'b1);
  endtask

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b1;
    flush_i = 1'b0;
    ready_i = 1'b1;
    ctrl_i  = 10'h3FF;
    data_i  = '1;
    repeat (2) step();
    rst_i = 1'b0;

    stream(8, 100, 0);
    stream(8, 3, 3);

    // Fill with 5,6 under back-pressure, then flush with 7 offered.
    idle(3, 1'b1);
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 143'd5;
    step();
    data_i = 143'd6;
    step();
    flush_i = 1'b1;
    data_i  = 143'd7;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    step();
    idle(4, 1'b1);

    // Bubbles with live-looking control on the input.
    valid_i = 1'b0;
    ctrl_i  = 10'h3FF;
    for (int k = 0; k < 8; k++) begin
      ready_i = 1'($urandom);
      step();
    end

    for (int k = 0; k < 500; k++) begin
      valid_i = ($urandom % 4) != 0;
      ready_i = ($urandom % 3) != 0;
      flush_i = ($urandom % 16) == 0;
      rst_i   = ($urandom % 64) == 0;
      ctrl_i  = 10'($urandom);
      rand_data(data_i);
      step();
    end
    rst_i = 1'b0;
    idle(5, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
